// File: rtl/inst_sram_resp.sv
// Single-port instruction SRAM responder with a post-reset INIT_VAL sweep.
// Optional access counters (rd_cnt/wr_cnt) are compiled in with INST_SRAM_ACC_CNT_EN.
module inst_sram_resp #(
    parameter int                 XLEN     = 32,
    parameter int                 AW       = 10,
    parameter logic [XLEN-1:0]    INIT_VAL = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inst_sram_en,
    input  logic [3:0]      inst_sram_wen,
    input  logic [XLEN-1:0] inst_sram_addr,
    input  logic [XLEN-1:0] inst_sram_wdata,
    output logic [XLEN-1:0] inst_sram_rdata,
    output logic            init_done,
    output logic            addr_err
`ifdef INST_SRAM_ACC_CNT_EN
    ,
    output logic [31:0]     rd_cnt,
    output logic [31:0]     wr_cnt
`endif
);

    // Handshake: a request is accepted on any RUN-state edge with inst_sram_en high;
    // there is no ready, so throughput is one access per cycle and rdata follows after one edge.
    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int DEPTH = 2 ** AW;

    logic [XLEN-1:0] r_mem [DEPTH];
    state_t          r_state;
    logic [AW-1:0]   r_ptr;
    logic [XLEN-1:0] r_rdata;
    logic            r_init_done;
    logic            r_addr_err;

    logic [AW-1:0]   w_idx;
    logic            w_in_range;
    logic            w_run_req;
    logic            w_rd;
    logic            w_wr;
    logic [XLEN-1:0] w_rd_word;
    logic            w_unused_addr_lsb;

    assign w_idx             = inst_sram_addr[AW+1:2];
    assign w_in_range        = (inst_sram_addr[XLEN-1:AW+2] == '0);
    assign w_run_req         = (r_state == ST_RUN) && inst_sram_en;
    assign w_rd              = w_run_req && (inst_sram_wen == 4'b0000);
    assign w_wr              = w_run_req && (inst_sram_wen != 4'b0000);
    assign w_rd_word         = r_mem[w_idx];
    assign w_unused_addr_lsb = ^inst_sram_addr[1:0];

    // Array has no reset; the sweep is what gives it defined contents.
    always_ff @(posedge clk) begin
        if (r_state == ST_SWEEP) begin
            r_mem[r_ptr] <= INIT_VAL;
        end else if (w_wr && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (inst_sram_wen[i]) begin
                    r_mem[w_idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_SWEEP;
            r_ptr       <= '0;
            r_rdata     <= '0;
            r_init_done <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_SWEEP: begin
                    r_addr_err <= 1'b0;
                    if (r_ptr == '1) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_addr_err <= w_run_req && !w_in_range;
                    if (w_rd) begin
                        r_rdata <= w_in_range ? w_rd_word : '0;
                    end
                end
                default: begin
                    r_state <= ST_SWEEP;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    assign inst_sram_rdata = r_rdata;
    assign init_done       = r_init_done;
    assign addr_err        = r_addr_err;

`ifdef INST_SRAM_ACC_CNT_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    // Only in-range RUN accesses count; both counters wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd && w_in_range) r_rd_cnt <= r_rd_cnt + 32'd1;
            if (w_wr && w_in_range) r_wr_cnt <= r_wr_cnt + 32'd1;
        end
    end

    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;
`else
    // Counters compiled out; no extra ports or state.
`endif

endmodule

// File: tb/tb_inst_sram_resp.sv
// Self-checking bench for inst_sram_resp (AW=4): sweep timing, byte writes,
// read hold, out-of-range handling, resets mid-sweep/mid-run, optional counters.
module tb_inst_sram_resp;

    localparam int AW = 4;

    logic        clk;
    logic        reset;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        init_done;
    logic        addr_err;
`ifdef INST_SRAM_ACC_CNT_EN
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
`endif

    inst_sram_resp #(.XLEN(32), .AW(AW), .INIT_VAL(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .init_done       (init_done),
        .addr_err        (addr_err)
`ifdef INST_SRAM_ACC_CNT_EN
        ,
        .rd_cnt          (rd_cnt),
        .wr_cnt          (wr_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want $finish before 2ms");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] model [16];
    logic [31:0] exp_rdata;
    logic [31:0] exp_q [$];
    logic [31:0] err_q [$];
    int          exp_rd_cnt;
    int          exp_wr_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    endtask

    task automatic model_sweep();
        for (int i = 0; i < 16; i++) model[i] = 32'h0000_0000;
        exp_rdata  = 32'h0;
        exp_rd_cnt = 0;
        exp_wr_cnt = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_req(input string tag, input logic en, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic       inr;
        logic [3:0] idx;
        logic [31:0] got_err;
        inr = (addr[31:6] == 26'd0);
        idx = addr[5:2];
        if (en && wen == 4'b0000) begin
            exp_rdata = inr ? model[idx] : 32'h0;
            if (inr) exp_rd_cnt++;
        end else if (en && inr) begin
            for (int i = 0; i < 4; i++)
                if (wen[i]) model[idx][8*i +: 8] = wdata[8*i +: 8];
            exp_wr_cnt++;
        end
        exp_q.push_back(exp_rdata);
        err_q.push_back({31'd0, en && !inr});
        inst_sram_en    = en;
        inst_sram_wen   = wen;
        inst_sram_addr  = addr;
        inst_sram_wdata = wdata;
        @(posedge clk);
        #1;
        got_err = {31'd0, addr_err};
        check_val({tag, "_rdata"}, inst_sram_rdata, exp_q.pop_front());
        check_val({tag, "_err"}, got_err, err_q.pop_front());
    endtask

    task automatic idle_inputs();
        inst_sram_en    = 1'b0;
        inst_sram_wen   = 4'h0;
        inst_sram_addr  = 32'h0;
        inst_sram_wdata = 32'h0;
    endtask

    // Counts edges until init_done, while hammering the DUT with requests that must be ignored.
    task automatic wait_sweep(output int cycles, output int viol);
        cycles = 0;
        viol   = 0;
        for (int k = 0; k < 200; k++) begin
            inst_sram_en    = 1'b1;
            inst_sram_wen   = (k % 2 == 0) ? 4'hF : 4'h0;
            inst_sram_addr  = (k % 2 == 0) ? 32'h0000_0008 : 32'h0000_0040;
            inst_sram_wdata = 32'hDEAD_BEEF;
            @(posedge clk);
            #1;
            cycles++;
            if (init_done) break;
            if (inst_sram_rdata !== 32'h0 || addr_err !== 1'b0) viol++;
        end
        idle_inputs();
        model_sweep();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int viol;
        logic [31:0] a;
        logic [3:0]  w;

        idle_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rdata", inst_sram_rdata, 32'h0);
        check_val("rst_init_done", {31'd0, init_done}, 32'd0);
        check_val("rst_addr_err", {31'd0, addr_err}, 32'd0);

        reset = 1'b1;
        wait_sweep(cyc, viol);
        check_val("sweep_len", cyc, 32'd16);
        check_val("sweep_ignored", viol, 32'd0);

        // First RUN cycle read: entry was written with INIT_VAL, request writes were dropped.
        do_req("first_run_rd", 1'b1, 4'h0, 32'h0000_003C, 32'h0);
        do_req("post_sweep_rd8", 1'b1, 4'h0, 32'h0000_0008, 32'h0);

        do_req("wr_full", 1'b1, 4'hF, 32'h0000_0008, 32'h1234_5678);
        do_req("wr_byte1", 1'b1, 4'b0010, 32'h0000_0008, 32'hAAAA_BBCC);
        do_req("rd_merge", 1'b1, 4'h0, 32'h0000_0008, 32'h0);
        check_val("byte_merge_const", inst_sram_rdata, 32'h1234_BB78);

        for (int i = 0; i < 5; i++) begin
            do_req("hold", 1'b0, 4'h0, (i % 2 == 0) ? 32'h0000_0004 : 32'h0000_0040, 32'h0);
            check_val("hold_const", inst_sram_rdata, 32'h1234_BB78);
        end

        do_req("oor_rd", 1'b1, 4'h0, 32'h0000_0040, 32'h0);
        do_req("oor_rd_gap", 1'b0, 4'h0, 32'h0, 32'h0);
        do_req("rd8_again", 1'b1, 4'h0, 32'h0000_0008, 32'h0);
        do_req("oor_wr", 1'b1, 4'hF, 32'h0000_0040, 32'hFFFF_FFFF);
        do_req("rd0_after_oor_wr", 1'b1, 4'h0, 32'h0000_0000, 32'h0);
        do_req("oor_rd_high", 1'b1, 4'h0, 32'h8000_0000, 32'h0);

        // Random back-to-back mix (reads/writes/idle/out-of-range every cycle).
        for (int i = 0; i < 60; i++) begin
            a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 1000)) << 6);
            w = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            do_req("rand", ($urandom_range(0, 5) != 0), w, a, $urandom);
        end

`ifdef INST_SRAM_ACC_CNT_EN
        check_val("rd_cnt_rand", rd_cnt, 32'(exp_rd_cnt));
        check_val("wr_cnt_rand", wr_cnt, 32'(exp_wr_cnt));
`endif

        // Mid-run reset clears rdata asynchronously, without waiting for an edge.
        do_req("pre_rst_wr", 1'b1, 4'hF, 32'h0000_0010, 32'hCAFE_F00D);
        do_req("pre_rst_rd", 1'b1, 4'h0, 32'h0000_0010, 32'h0);
        reset = 1'b0;
        #1;
        check_val("async_rst_rdata", inst_sram_rdata, 32'h0);
        check_val("async_rst_init_done", {31'd0, init_done}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset again seven cycles into the sweep; the sweep must restart in full.
        for (int k = 0; k < 7; k++) begin
            inst_sram_en    = 1'b1;
            inst_sram_wen   = 4'hF;
            inst_sram_addr  = 32'h0000_0010;
            inst_sram_wdata = 32'h5555_AAAA;
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        check_val("midsweep_init_done", {31'd0, init_done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        wait_sweep(cyc, viol);
        check_val("resweep_len", cyc, 32'd16);
        check_val("resweep_ignored", viol, 32'd0);
        do_req("resweep_rd10", 1'b1, 4'h0, 32'h0000_0010, 32'h0);
        do_req("resweep_rd8", 1'b1, 4'h0, 32'h0000_0008, 32'h0);

`ifdef INST_SRAM_ACC_CNT_EN
        // Clear by reset, then 3 reads (2 already above), 2 writes, 1 out-of-range read.
        do_req("cnt_rd3", 1'b1, 4'h0, 32'h0000_0004, 32'h0);
        do_req("cnt_wr1", 1'b1, 4'h3, 32'h0000_0004, 32'h0102_0304);
        do_req("cnt_wr2", 1'b1, 4'hC, 32'h0000_000C, 32'h0A0B_0C0D);
        do_req("cnt_oor", 1'b1, 4'h0, 32'h0000_0100, 32'h0);
        check_val("rd_cnt", rd_cnt, 32'd3);
        check_val("wr_cnt", wr_cnt, 32'd2);
`endif

        idle_inputs();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inst_sram_resp.md
Name: inst_sram_resp

Overview:
- Single-port synchronous instruction SRAM responder: the memory-side end of the fetch-stage inst_sram_* request interface (en/wen/addr/wdata in, rdata out).
- Read data is returned one cycle after an accepted read and held stable until the next accepted read, so a stalled fetch stage keeps sampling a valid instruction.
- A post-reset sweep FSM fills the array with INIT_VAL before normal service starts.
- Also used by the testbench and FPGA top as the instruction memory.

Parameters:
- XLEN, 32: address/data width; equals `XLEN.
- AW, 10: word-address width; depth = 2**AW words.
- INIT_VAL, 32'h0000_0000: word written to every entry by the sweep (0 is MIPS nop).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (low = in reset).
- inst_sram_en  in  1  request valid this cycle.
- inst_sram_wen  in  4  byte write enables; 0 = read, nonzero = write.
- inst_sram_addr  in  XLEN  byte address.
- inst_sram_wdata  in  XLEN  write data; byte i = bits 8i+7:8i.
- inst_sram_rdata  out  XLEN  registered read data.
- init_done  out  1  1 once the sweep completes; 0 during reset and sweep.
- addr_err  out  1  one-cycle pulse for an accepted out-of-range access.

Behaviour:
- Word index = addr[AW+1:2]. addr[1:0] is ignored (word-aligned fetch).
- An address is out of range when addr[XLEN-1:AW+2] != 0.
- Reset (async, reset low):
  - FSM goes to SWEEP with sweep pointer = 0.
  - rdata = 0, init_done = 0, addr_err = 0.
  - Array contents are not reset asynchronously.
- FSM states:
  - SWEEP: each cycle writes INIT_VAL to array[ptr], then ptr += 1. At ptr == 2**AW-1 the write completes and the FSM moves to RUN next cycle. Total sweep = 2**AW cycles.
  - RUN: normal service; no exit except reset.
  - Reset asserted mid-sweep or mid-run returns to SWEEP with ptr = 0 and restarts the sweep.
- init_done = 1 exactly in RUN; it is registered and rises the cycle after the last sweep write.
- During SWEEP: all requests are ignored, no array change, rdata holds 0, addr_err stays 0.
- RUN, en=1, wen=0 (read):
  - In range: rdata = array[idx] at the next edge (latency 1).
  - Out of range: rdata = 0 next cycle, and addr_err pulses for 1 cycle.
- RUN, en=1, wen!=0 (write):
  - In range: each byte i with wen[i]=1 is updated at the edge; other bytes are kept.
  - Out of range: the write is dropped and addr_err pulses.
  - rdata is unchanged by any write.
- RUN, en=0: no array change; rdata holds its previous value indefinitely.
- Read after write to the same address (consecutive cycles) returns the new data. There is no same-cycle read/write, because the memory is single-port.
- Back-to-back reads with en=1 every cycle produce a new rdata every cycle (full throughput, no stall, no ready signal).
- Reads in the first RUN cycle are serviced normally.

Optional Feature:
- Macro: INST_SRAM_ACC_CNT_EN.
- When defined:
  - Adds outputs rd_cnt [31:0] and wr_cnt [31:0].
  - Each counter increments by 1 per accepted in-range read/write in RUN. Out-of-range and SWEEP-cycle requests are not counted.
  - Counters wrap 32'hFFFF_FFFF -> 0 and clear to 0 on reset.
- When undefined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Sweep: assert reset low 3 cycles, release with AW=4 -> init_done=0 for exactly 16 cycles, then 1; a read of addr 0x3C in RUN -> rdata=0x0000_0000 next cycle.
- Byte write: RUN, write addr 0x8 wen=4'hF data 0x1234_5678, then wen=4'b0010 data 0xAAAA_BBCC, then read 0x8 -> rdata=0x1234_BB78 one cycle after the read.
- Hold: read 0x8 (rdata=0x1234_BB78), then en=0 for 5 cycles while addr toggles -> rdata stays 0x1234_BB78 throughout.
- Out of range: AW=4, read addr 0x40 -> addr_err pulses 1 cycle, rdata=0; write 0x40 -> addr_err pulse, array entry 0 unchanged.
- Mid-sweep reset: pull reset low at sweep cycle 7 after writing nothing -> sweep restarts, init_done rises exactly 16 cycles after release; requests issued during the sweep have no effect.
- With INST_SRAM_ACC_CNT_EN: 3 reads, 2 writes, 1 out-of-range read in RUN -> rd_cnt=3, wr_cnt=2.
